// File: rtl/fxp_div.sv
// fxp_div: iterative signed Q(int_bits).(frac_bits) restoring divider with start/busy/done handshake.
// Define FXP_DIV_SAT_EN to saturate on overflow; otherwise the quotient wraps.
module fxp_div #(
    parameter int int_bits   = 8,
    parameter int frac_bits  = 8,
    parameter int total_bits = int_bits + frac_bits
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [total_bits-1:0] a,
    input  logic [total_bits-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [total_bits-1:0] result,
    output logic                  overflow,
    output logic                  div_by_zero
);
    localparam int dw = total_bits + frac_bits;
    localparam int cw = $clog2(dw + 1);
    localparam logic [dw-1:0] pos_max = (dw'(1) << (total_bits - 1)) - dw'(1);
    localparam logic [dw-1:0] neg_max = dw'(1) << (total_bits - 1);
    localparam logic [total_bits-1:0] smax = {1'b0, {(total_bits-1){1'b1}}};
    localparam logic [total_bits-1:0] smin = {1'b1, {(total_bits-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_nx;
    logic [dw-1:0] dvd, quo, sq;
    logic [total_bits:0] rem, rem_sh;
    logic [total_bits-1:0] abs_a, abs_b, dvs, fix_res;
    logic [cw-1:0] cnt;
    logic sign, a_neg, dz, ge, fix_ovf;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        abs_a = a[total_bits-1] ? -a : a;
        abs_b = b[total_bits-1] ? -b : b;
        rem_sh = {rem[total_bits-1:0], dvd[dw-1]};
        ge = rem_sh >= {1'b0, dvs};
        sq = sign ? -quo : quo;
        // negative results may reach one step further than positive ones
        fix_ovf = !dz && (quo > (sign ? neg_max : pos_max));
`ifdef FXP_DIV_SAT_EN
        fix_res = dz ? (a_neg ? smin : smax) : fix_ovf ? (sign ? smin : smax) : sq[total_bits-1:0];
`else
        fix_res = dz ? (a_neg ? smin : smax) : sq[total_bits-1:0];
`endif
        state_nx = state == IDLE ? (start ? (b == '0 ? FIX : CALC) : IDLE) :
                   state == CALC ? (cnt == cw'(1) ? FIX : CALC) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd <= '0;
            quo <= '0;
            rem <= '0;
            dvs <= '0;
            cnt <= '0;
            sign <= 1'b0;
            a_neg <= 1'b0;
            dz <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            result <= '0;
            overflow <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                sign <= a[total_bits-1] ^ b[total_bits-1];
                a_neg <= a[total_bits-1];
                dz <= b == '0;
                dvd <= {abs_a, {frac_bits{1'b0}}};
                dvs <= abs_b;
                rem <= '0;
                quo <= '0;
                cnt <= cw'(dw);
                busy <= 1'b1;
                overflow <= 1'b0;
                div_by_zero <= 1'b0;
            end else if (state == CALC) begin
                rem <= ge ? rem_sh - {1'b0, dvs} : rem_sh;
                quo <= {quo[dw-2:0], ge};
                dvd <= dvd << 1;
                cnt <= cnt - cw'(1);
            end else if (state == FIX) begin
                result <= fix_res;
                overflow <= fix_ovf;
                div_by_zero <= dz;
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fxp_div.sv
// tb_fxp_div: directed vector table plus handshake and reset sequences for fxp_div.
module tb_fxp_div;
    logic clk = 1'b0;
    logic rst_n, start, busy, done, overflow, div_by_zero;
    logic [15:0] a, b, result;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic [15:0] a, b, r;
        logic ov, dz;
        int lat;
    } vec_t;
    vec_t v[12];
    fxp_div dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .busy(busy),
        .done(done), .result(result), .overflow(overflow), .div_by_zero(div_by_zero)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask
    // called at the negedge following the accepting edge
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc = 0;
        while (!done && lat < 100) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic launch(input logic [15:0] ta, input logic [15:0] tb_);
        a = ta;
        b = tb_;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask
    initial begin
        int lat, bc, ndone;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        v[0]  = '{16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 25};
        v[1]  = '{16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, 25};
        v[2]  = '{16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 25};
        v[3]  = '{16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0, 25};
        v[4]  = '{16'h8000, 16'h8000, 16'h0100, 1'b0, 1'b0, 25};
`ifdef FXP_DIV_SAT_EN
        v[5]  = '{16'h7F00, 16'h0080, 16'h7FFF, 1'b1, 1'b0, 25};
        v[6]  = '{16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0, 25};
`else
        v[5]  = '{16'h7F00, 16'h0080, 16'hFE00, 1'b1, 1'b0, 25};
        v[6]  = '{16'h8000, 16'hFF00, 16'h8000, 1'b1, 1'b0, 25};
`endif
        v[7]  = '{16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, 25};
        v[8]  = '{16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1, 1};
        v[9]  = '{16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b0, 25};
        v[10] = '{16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 1};
        v[11] = '{16'h0080, 16'hFF80, 16'hFF00, 1'b0, 1'b0, 25};
        #7;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_dz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            launch(v[i].a, v[i].b);
            wait_done(lat, bc);
            chk($sformatf("v%0d_lat", i), lat, v[i].lat);
            chk($sformatf("v%0d_busycyc", i), bc, v[i].lat);
            chk($sformatf("v%0d_busy_at_done", i), busy, 0);
            chk($sformatf("v%0d_result", i), result, v[i].r);
            chk($sformatf("v%0d_ovf", i), overflow, v[i].ov);
            chk($sformatf("v%0d_dz", i), div_by_zero, v[i].dz);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), done, 0);
            chk($sformatf("v%0d_result_held", i), result, v[i].r);
        end
        launch(16'h0300, 16'h0200);
        repeat (9) @(negedge clk);
        launch(16'h0100, 16'h0300);
        wait_done(lat, bc);
        chk("ignored_start_lat", lat, 15);
        chk("ignored_start_result", result, 16'h0180);
        launch(16'h0100, 16'h0300);
        wait_done(lat, bc);
        chk("b2b_lat", lat, 25);
        chk("b2b_result", result, 16'h0055);
        @(negedge clk);
        launch(16'h0300, 16'h0200);
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_result", result, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_dz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("arst_no_done", ndone, 0);
        launch(16'hFD00, 16'h0200);
        wait_done(lat, bc);
        chk("post_rst_lat", lat, 25);
        chk("post_rst_result", result, 16'hFE80);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
